// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master port between NREQ local requesters.
// Round-robin arbitration in IDLE, then a standard SETUP/ACCESS sequence with
// a bounded wait on PREADY. Completion is reported to the winner as a one-cycle
// ack together with read data and an error flag.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [ADDR_W-1:0]        PADDR,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [DATA_W-1:0]        PWDATA,
  input  logic [DATA_W-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  logic [NREQ-1:0]  eligible;
  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  next_ptr;
  int               idx;

  // Round-robin search: first eligible requester at or above ptr, wrapping.
  // A requester being acked this cycle is masked so it cannot be re-granted
  // before it has had the chance to drop its request.
  always_comb begin
    eligible = req & ~ack;
    found    = 1'b0;
    winner   = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
    if (int'(winner) == NREQ - 1) begin
      next_ptr = '0;
    end else begin
      next_ptr = winner + 1'b1;
    end
  end

  // Transfer sequencer: grant in IDLE, one SETUP cycle, then ACCESS until
  // PREADY or the wait budget runs out; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      grant_id <= '0;
      busy     <= 1'b0;
      PADDR    <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PWDATA   <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            PADDR    <= req_addr[winner*ADDR_W +: ADDR_W];
            PWRITE   <= req_write[winner];
            PWDATA   <= req_wdata[winner*DATA_W +: DATA_W];
            grant_id <= winner;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            busy     <= 1'b1;
            ptr      <= next_ptr;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            ack[grant_id] <= 1'b1;
            if (!PWRITE) begin
              rdata <= PRDATA;
            end
            err     <= PSLVERR;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Slave never answered: abort with an error, keep old read data.
            ack[grant_id] <= 1'b1;
            err           <= 1'b1;
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed stimulus with a scoreboard queue of expected
// completions, a simple APB slave model and requesters that drop req after ack.
module tb_apb_req_arbiter;

  localparam int NREQ    = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   err;
  logic [1:0]             grant_id;
  logic                   busy;
  logic [ADDR_W-1:0]      PADDR;
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [DATA_W-1:0]      PWDATA;
  logic [DATA_W-1:0]      PRDATA;
  logic                   PREADY = 1'b0;
  logic                   PSLVERR;

  typedef struct {
    int          id;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] slave_base = '0;
  logic [7:0]  err_addr   = 8'hFF;
  logic [7:0]  stuck_addr = 8'hFF;
  int          wait_n     = 0;
  int          acc_cnt    = 0;
  logic [3:0]  ack_q      = '0;

  apb_req_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err), .grant_id(grant_id),
    .busy(busy), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  // Slave read data depends on the address so each read is distinguishable.
  assign PRDATA  = slave_base + {24'h0, PADDR};
  assign PSLVERR = PREADY && (PADDR == err_addr);

  // Slave: PREADY rises after wait_n ACCESS cycles, never for stuck_addr.
  always @(negedge clk) begin
    if (PSEL && PENABLE) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
    PREADY = PSEL && PENABLE && (acc_cnt > wait_n) && (PADDR != stuck_addr);
  end

  // Requesters drop their request on the edge after their ack.
  always @(posedge clk) begin
    ack_q = ack;
    #1;
    req = req & ~ack_q;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] addr, input logic wr,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input logic exp_err);
    exp_t e;
    req_addr[id*ADDR_W +: ADDR_W]  = addr;
    req_write[id]                  = wr;
    req_wdata[id*DATA_W +: DATA_W] = wd;
    req[id]                        = 1'b1;
    e.id = id; e.addr = addr; e.wr = wr; e.wdata = wd; e.rdata = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
  endtask

  // Wait at negedges for an ack, counting ACCESS cycles seen on the way.
  task automatic waitAck(input string name, input int limit, output int access_cycles,
                         output logic [3:0] seen);
    access_cycles = 0;
    seen = '0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) access_cycles++;
      if (ack != '0) begin
        seen = ack;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s_timeout: no ack within %0d cycles", name, limit);
  endtask

  task automatic drainQueue(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL drain: %0d expected completions outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"},      32'(ack), 32'd0);
    checkOutput({tag, "_rdata"},    rdata, 32'd0);
    checkOutput({tag, "_err"},      32'(err), 32'd0);
    checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy), 32'd0);
    checkOutput({tag, "_paddr"},    32'(PADDR), 32'd0);
    checkOutput({tag, "_psel"},     32'(PSEL), 32'd0);
    checkOutput({tag, "_penable"},  32'(PENABLE), 32'd0);
    checkOutput({tag, "_pwrite"},   32'(PWRITE), 32'd0);
    checkOutput({tag, "_pwdata"},   PWDATA, 32'd0);
  endtask

  // Monitor: pops an expected completion whenever the DUT acks, and checks
  // the bus against the head of the queue during every ACCESS cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ack_onehot",       32'(ack), 32'(1) << e.id);
          checkOutput("ack_grant_id",     32'(grant_id), 32'(e.id));
          checkOutput("ack_err",          32'(err), 32'(e.err));
          checkOutput("ack_rdata",        rdata, e.rdata);
          checkOutput("ack_bus_released", 32'({PSEL, PENABLE, busy}), 32'd0);
        end
      end else begin
        checkOutput("err_without_ack", 32'(err), 32'd0);
      end
      if (PSEL && PENABLE && exp_q.size() != 0) begin
        checkOutput("access_paddr",    32'(PADDR), 32'(exp_q[0].addr));
        checkOutput("access_pwrite",   32'(PWRITE), 32'(exp_q[0].wr));
        checkOutput("access_grant_id", 32'(grant_id), 32'(exp_q[0].id));
        if (exp_q[0].wr) checkOutput("access_pwdata", PWDATA, exp_q[0].wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         ac;
    logic [3:0] seen;
    bit         in_access;
    rst = 1'b1;
    req = '0; req_addr = '0; req_write = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // Test 1: zero-wait read from requester 0
    @(negedge clk);
    slave_base = 32'hDEADBEEB;
    applyStimulus(0, 8'h04, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    checkOutput("t1_psel_e0",     32'(PSEL), 32'd1);
    checkOutput("t1_penable_e0",  32'(PENABLE), 32'd0);
    checkOutput("t1_busy_e0",     32'(busy), 32'd1);
    checkOutput("t1_grant_id_e0", 32'(grant_id), 32'd0);
    checkOutput("t1_paddr_e0",    32'(PADDR), 32'h04);
    @(negedge clk);
    checkOutput("t1_penable_e1",  32'(PENABLE), 32'd1);
    @(negedge clk);
    checkOutput("t1_ack_e2",      32'(ack), 32'h1);
    checkOutput("t1_rdata_e2",    rdata, 32'hDEADBEEF);
    checkOutput("t1_err_e2",      32'(err), 32'd0);
    drainQueue(10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Test 2: all four at once, served 0..3 with one idle cycle between
    @(negedge clk);
    slave_base = 32'h0BADF000;
    applyStimulus(0, 8'h10, 1'b1, 32'h11110000, 32'h00000000, 1'b0);
    applyStimulus(1, 8'h14, 1'b0, 32'h0,        32'h0BADF014, 1'b0);
    applyStimulus(2, 8'h18, 1'b1, 32'h33330000, 32'h0BADF014, 1'b0);
    applyStimulus(3, 8'h1C, 1'b0, 32'h0,        32'h0BADF01C, 1'b0);
    for (int k = 0; k < 3; k++) begin
      waitAck("t2_ack", 20, ac, seen);
      checkOutput("t2_ack_id", 32'(seen), 32'(1) << k);
      @(negedge clk);
      checkOutput("t2_regrant_psel",    32'(PSEL), 32'd1);
      checkOutput("t2_regrant_penable", 32'(PENABLE), 32'd0);
      checkOutput("t2_regrant_id",      32'(grant_id), 32'(k + 1));
    end
    waitAck("t2_ack_last", 20, ac, seen);
    checkOutput("t2_ack_id_last", 32'(seen), 32'h8);
    drainQueue(10);

    // Test 3: write with PREADY low for three ACCESS cycles
    @(negedge clk);
    wait_n = 3;
    applyStimulus(1, 8'h00, 1'b1, 32'h12345678, 32'h0BADF01C, 1'b0);
    waitAck("t3_ack", 40, ac, seen);
    checkOutput("t3_ack_id",        32'(seen), 32'h2);
    checkOutput("t3_access_cycles", 32'(ac), 32'd4);
    drainQueue(10);
    wait_n = 0;

    // Test 4: slave error on a read, next transfer clean
    @(negedge clk);
    err_addr   = 8'h20;
    slave_base = 32'h55550000;
    applyStimulus(2, 8'h20, 1'b0, 32'h0, 32'h55550020, 1'b1);
    applyStimulus(3, 8'h24, 1'b0, 32'h0, 32'h55550024, 1'b0);
    waitAck("t4_ack_a", 20, ac, seen);
    checkOutput("t4_ack_id_a", 32'(seen), 32'h4);
    waitAck("t4_ack_b", 20, ac, seen);
    checkOutput("t4_ack_id_b", 32'(seen), 32'h8);
    drainQueue(10);
    err_addr = 8'hFF;

    // Test 5: PREADY stuck low -> timeout abort, then next requester served
    @(negedge clk);
    stuck_addr = 8'h30;
    applyStimulus(0, 8'h30, 1'b0, 32'h0, 32'h55550024, 1'b1);
    applyStimulus(1, 8'h34, 1'b0, 32'h0, 32'h55550034, 1'b0);
    waitAck("t5_ack_timeout", 60, ac, seen);
    checkOutput("t5_ack_id_timeout",   32'(seen), 32'h1);
    checkOutput("t5_timeout_cycles",   32'(ac), 32'(TIMEOUT));
    waitAck("t5_ack_next", 20, ac, seen);
    checkOutput("t5_ack_id_next",      32'(seen), 32'h2);
    drainQueue(10);
    stuck_addr = 8'hFF;

    // Test 6: reset asserted in ACCESS, then a clean transfer from requester 2
    @(negedge clk);
    wait_n = 10;
    applyStimulus(2, 8'h40, 1'b0, 32'h0, 32'h0, 1'b0);
    in_access = 1'b0;
    for (int i = 0; i < 10 && !in_access; i++) begin
      @(negedge clk);
      if (PSEL && PENABLE) in_access = 1'b1;
    end
    checkOutput("t6_reached_access", 32'(in_access), 32'd1);
    @(negedge clk);
    #2;
    exp_q.delete();
    req = '0;
    rst = 1'b1;
    #1;
    checkResetState("t6_async");
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    wait_n = 0;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_ack_after_reset", 32'(ack), 32'd0);
    slave_base = 32'h77770000;
    applyStimulus(2, 8'h44, 1'b0, 32'h0, 32'h77770044, 1'b0);
    @(negedge clk);
    checkOutput("t6_grant_id", 32'(grant_id), 32'd2);
    checkOutput("t6_psel",     32'(PSEL), 32'd1);
    waitAck("t6_ack", 20, ac, seen);
    checkOutput("t6_ack_id", 32'(seen), 32'h4);
    drainQueue(10);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
